// File: rtl/prog_sequencer.sv
// Program-start sequencer: turns the Start pulse into PC load/hold control and raises Ack on Halt.
// Define SEQ_CYCLE_COUNT_EN to enable the saturating RUN-cycle counter on CycleCount.
module prog_sequencer #(
   parameter int A        = 10,
   parameter int NUM_PROG = 3,
   parameter int BASE0    = 0,
   parameter int BASE1    = 100,
   parameter int BASE2    = 200,
   parameter int CW       = 32
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic          Halt,
   output logic          PcLoad,
   output logic [A-1:0]  PcLoadValue,
   output logic          PcHold,
   output logic          Ack,
   output logic [1:0]    ProgIdx,
   output logic          Running,
   output logic [CW-1:0] CycleCount
);
   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

   localparam logic [1:0] LAST_PROG = 2'(NUM_PROG);

   state_t       state_reg, state_next;
   logic         start_r;
   logic [1:0]   prog_idx_reg, prog_idx_next;
   logic         ack_reg, ack_next;
   logic         rise, fall, pc_load;
   logic [A-1:0] base_tab [0:3];

   // Entry 0 covers "no program launched yet"; entries 1..3 are the program bases.
   assign base_tab[0] = '0;
   genvar gi;
   generate
      for (gi = 1; gi < 4; gi++) begin : g_base
         localparam int BASE_VAL = (gi == 1) ? BASE0 : (gi == 2) ? BASE1 : BASE2;
         assign base_tab[gi] = A'(BASE_VAL);
      end
   endgenerate

   assign rise = Start & ~start_r;
   assign fall = ~Start & start_r;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg    <= IDLE;
         start_r      <= 1'b0;
         prog_idx_reg <= '0;
         ack_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         start_r      <= Start;
         prog_idx_reg <= prog_idx_next;
         ack_reg      <= ack_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      prog_idx_next = prog_idx_reg;
      ack_next      = ack_reg;
      case (state_reg)
         IDLE, DONE: begin
            // Once every program has run, further arms are ignored and Ack stays up.
            if (rise && (prog_idx_reg < LAST_PROG)) begin
               state_next    = ARMED;
               prog_idx_next = prog_idx_reg + 2'd1;
               ack_next      = 1'b0;
            end
         end
         ARMED: begin
            if (fall) state_next = RUN;
         end
         RUN: begin
            if (Halt) begin
               state_next = DONE;
               ack_next   = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign pc_load     = ~Reset & (state_reg == ARMED) & fall;
   assign PcLoad      = pc_load;
   assign PcLoadValue = base_tab[prog_idx_reg];
   assign PcHold      = Reset | (~pc_load & (state_reg != RUN));
   assign Ack         = ack_reg;
   assign ProgIdx     = prog_idx_reg;
   assign Running     = (state_reg == RUN);

`ifdef SEQ_CYCLE_COUNT_EN
   logic [CW-1:0] cycle_cnt_reg;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         cycle_cnt_reg <= '0;
      end else if (pc_load) begin
         cycle_cnt_reg <= '0;
      end else if ((state_reg == RUN) && (cycle_cnt_reg != '1)) begin
         cycle_cnt_reg <= cycle_cnt_reg + CW'(1);
      end
   end

   assign CycleCount = cycle_cnt_reg;
`else
   assign CycleCount = '0;
`endif

endmodule
